mem_io_ctrl: RTL and testbench

Bus responder at the far end of the CPU's byte-wide memory port. It decodes each cycle's address, write strobe and write data into a 128 KB synchronous RAM or the memory-mapped I/O space. The I/O space covers a UART transmit FIFO, a receive holding byte, a free-running cycle counter and a program-stop latch. It sits between the CPU top and the UART/board I/O, and drives the read-data bus and `io_buffer_full` seen by the CPU.

---
 rtl/mem_io_ctrl.sv | 157 +++++++++++++++
 tb/tb_mem_io_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: byte-wide CPU memory responder.
// Decodes each bus cycle into a 128 KB RAM or the I/O space (UART TX FIFO,
// RX holding byte, free-running cycle counter, program-stop latch).
// Optional build macro: MEMIO_COUNTER_SNAPSHOT_EN (coherent 4-byte counter read).
module mem_io_ctrl #(
    parameter int ADDR_WIDTH   = 17,
    parameter int TX_DEPTH     = 8,
    parameter int TX_PTR_WIDTH = 3,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_stop,
    output logic        tx_overflow
);

    localparam logic [17:0]           IO_DATA  = 18'h30000;
    localparam logic [17:0]           IO_CNT0  = 18'h30004;
    localparam logic [TX_PTR_WIDTH:0] OCC_FULL = (TX_PTR_WIDTH+1)'(TX_DEPTH);
    localparam logic [TX_PTR_WIDTH:0] OCC_HIGH = (TX_PTR_WIDTH+1)'(TX_DEPTH - FULL_MARGIN);

    logic [7:0]              ram [0:(2**ADDR_WIDTH)-1];
    logic [7:0]              ram_q;
    logic [7:0]              io_q;
    logic                    rd_src_ram;
    logic [7:0]              tx_mem [0:TX_DEPTH-1];
    logic [TX_PTR_WIDTH:0]   wr_ptr, rd_ptr, occupancy;
    logic                    tx_full, tx_pop, push_req, push_ok, stop_wr;
    logic [7:0]              push_data;
    logic                    rx_full, rx_pop, rx_load;
    logic [7:0]              rx_hold;
    logic [31:0]             cycle_cnt;
    logic                    is_io;
    logic [17:0]             io_off;
    logic [7:0]              io_rd_byte;
    logic                    unused_addr_bits;
`ifdef MEMIO_COUNTER_SNAPSHOT_EN
    logic [31:0]             cnt_snap;
`endif

    assign unused_addr_bits = ^cpu_a[31:18];

    // Bus decode, FIFO/RX handshakes and the I/O read multiplexer
    always_comb begin
        is_io      = (cpu_a[17:16] == 2'b11);
        io_off     = cpu_a[17:0];
        occupancy  = wr_ptr - rd_ptr;
        tx_full    = (occupancy == OCC_FULL);
        tx_valid   = (occupancy != '0);
        io_buffer_full = (occupancy >= OCC_HIGH);
        tx_data    = tx_mem[rd_ptr[TX_PTR_WIDTH-1:0]];
        tx_pop     = tx_valid && tx_ready;
        stop_wr    = is_io && cpu_wr && (io_off == IO_CNT0);
        push_req   = stop_wr || (is_io && cpu_wr && (io_off == IO_DATA) && (cpu_dout != '0));
        push_data  = stop_wr ? 8'h00 : cpu_dout;
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
        push_ok    = push_req && (!tx_full || tx_pop);
        rx_pop     = is_io && !cpu_wr && (io_off == IO_DATA);
        // The CPU draining the holding byte this cycle makes room for the new one
        rx_ready   = !rx_full || rx_pop;
        rx_load    = rx_valid && rx_ready;
        io_rd_byte = '0;
        if (io_off == IO_DATA) begin
            io_rd_byte = rx_full ? rx_hold : 8'h00;
        end else if (io_off[17:2] == IO_CNT0[17:2]) begin
`ifdef MEMIO_COUNTER_SNAPSHOT_EN
            if (io_off[1:0] == 2'b00) io_rd_byte = cycle_cnt[7:0];
            else                      io_rd_byte = cnt_snap[{io_off[1:0], 3'b000} +: 8];
`else
            io_rd_byte = cycle_cnt[{io_off[1:0], 3'b000} +: 8];
`endif
        end
    end

    // RAM array: synchronous write, registered read (not reset)
    always_ff @(posedge clk_in) begin
        if (!is_io) begin
            if (cpu_wr) ram[cpu_a[ADDR_WIDTH-1:0]] <= cpu_dout;
            else        ram_q <= ram[cpu_a[ADDR_WIDTH-1:0]];
        end
    end

    // Read-data source select and I/O read register; reset forces cpu_din to zero
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rd_src_ram <= 1'b0;
            io_q       <= '0;
        end else if (!cpu_wr) begin
            rd_src_ram <= !is_io;
            if (is_io) io_q <= io_rd_byte;
        end
    end

    assign cpu_din = rd_src_ram ? ram_q : io_q;

    // TX FIFO pointers and sticky overflow flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push_ok)              wr_ptr      <= wr_ptr + 1'b1;
            if (tx_pop)               rd_ptr      <= rd_ptr + 1'b1;
            if (push_req && !push_ok) tx_overflow <= 1'b1;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk_in) begin
        if (push_ok) tx_mem[wr_ptr[TX_PTR_WIDTH-1:0]] <= push_data;
    end

    // RX holding register
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rx_full <= 1'b0;
            rx_hold <= '0;
        end else if (rx_load) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end
    end

    // Cycle counter (frozen by program stop) and the stop latch
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt    <= '0;
            program_stop <= 1'b0;
        end else begin
            if (!program_stop) cycle_cnt    <= cycle_cnt + 1'b1;
            if (stop_wr)       program_stop <= 1'b1;
        end
    end

`ifdef MEMIO_COUNTER_SNAPSHOT_EN
    // Counter snapshot taken when byte 0 is read
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                                      cnt_snap <= '0;
        else if (is_io && !cpu_wr && io_off == IO_CNT0)   cnt_snap <= cycle_cnt;
    end
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Self-checking bench for mem_io_ctrl: directed test-plan sequences followed by
// randomized bus traffic, all compared against a behavioural model.
module tb_mem_io_ctrl;

    localparam int TX_DEPTH = 8;
    localparam int FULL_AT  = TX_DEPTH - 2;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic [31:0] cpu_a = '0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_dout = '0;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        program_stop;
    logic        tx_overflow;

    int errors = 0;
    int checks = 0;

    mem_io_ctrl #(
        .ADDR_WIDTH(17), .TX_DEPTH(TX_DEPTH), .TX_PTR_WIDTH(3), .FULL_MARGIN(2)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    bit          rx_v;
    logic [7:0]  rx_b;
    int unsigned cnt;
    int unsigned snap;
    bit          stop_m, ovf_m, din_known;
    logic [7:0]  din_m;
    int unsigned pool [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int unsigned v, input int k);
        int unsigned s;
        s = v >> (8 * k);
        return s[7:0];
    endfunction

    task automatic model_reset();
        txq.delete();
        rx_v = 0; rx_b = '0; cnt = 0; snap = 0;
        stop_m = 0; ovf_m = 0; din_m = '0; din_known = 1;
    endtask

    function automatic bit cur_rx_pop();
        return (cpu_a[17:16] == 2'b11) && !cpu_wr && (cpu_a[17:0] == 18'h30000);
    endfunction

    task automatic check_outputs();
        if (din_known) check("cpu_din", cpu_din, din_m);
        check("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
        check("io_buffer_full", io_buffer_full, txq.size() >= FULL_AT);
        check("tx_overflow", tx_overflow, ovf_m);
        check("program_stop", program_stop, stop_m);
        check("rx_ready", rx_ready, !rx_v || cur_rx_pop());
    endtask

    // One bus cycle: advance the model from the driven inputs, clock, compare
    task automatic step();
        bit io, pop, rxpop, push_req, load;
        logic [17:0] off;
        int size_before, k;
        io = (cpu_a[17:16] == 2'b11);
        off = cpu_a[17:0];
        size_before = txq.size();
        pop = (size_before != 0) && tx_ready;
        rxpop = cur_rx_pop();
        if (!cpu_wr) begin
            if (!io) begin
                din_known = ram_m.exists(int'(cpu_a[16:0]));
                if (din_known) din_m = ram_m[int'(cpu_a[16:0])];
            end else begin
                din_known = 1; din_m = 8'h00;
                if (off == 18'h30000) din_m = rx_v ? rx_b : 8'h00;
                else if (off >= 18'h30004 && off <= 18'h30007) begin
                    k = int'(off) - 'h30004;
`ifdef MEMIO_COUNTER_SNAPSHOT_EN
                    if (k == 0) begin din_m = byte_of(cnt, 0); snap = cnt; end
                    else din_m = byte_of(snap, k);
`else
                    din_m = byte_of(cnt, k);
`endif
                end
            end
        end
        push_req = io && cpu_wr && ((off == 18'h30000 && cpu_dout != 0) || off == 18'h30004);
        if (pop) void'(txq.pop_front());
        if (push_req) begin
            if (size_before < TX_DEPTH || pop) txq.push_back((off == 18'h30004) ? 8'h00 : cpu_dout);
            else ovf_m = 1;
        end
        load = rx_valid && (!rx_v || rxpop);
        if (load) begin rx_v = 1; rx_b = rx_data; end
        else if (rxpop) rx_v = 0;
        if (!stop_m) cnt++;
        if (io && cpu_wr && off == 18'h30004) stop_m = 1;
        if (!io && cpu_wr) ram_m[int'(cpu_a[16:0])] = cpu_dout;
        @(posedge clk_in); #1;
        check_outputs();
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [7:0] d);
        cpu_a = a; cpu_wr = w; cpu_dout = d;
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_cpu_din"}, cpu_din, 8'h00);
        check({tag, "_buf_full"}, io_buffer_full, 1'b0);
        check({tag, "_overflow"}, tx_overflow, 1'b0);
        check({tag, "_stop"}, program_stop, 1'b0);
        check({tag, "_rx_ready"}, rx_ready, 1'b1);
    endtask

    // Asynchronous reset asserted between clock edges, held one edge, then released
    task automatic async_reset(input string tag);
        @(posedge clk_in); #3;
        cpu_a = '0; cpu_wr = 1'b0; rx_valid = 1'b0;
        rst_in = 1'b0;
        #1;
        check_reset_state(tag);
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
    endtask

    initial begin
        int r;
        logic [7:0] d;
        model_reset();
        #12;
        check_reset_state("por");
        @(posedge clk_in); #1;
        rst_in = 1'b1;

        // RAM round trips, including the top byte of the array
        bus(32'h0000_0123, 1'b1, 8'hA5);
        bus(32'h0000_0123, 1'b0, 8'h00);
        check("ram_0123", cpu_din, 8'hA5);
        bus(32'h0001_FFFF, 1'b1, 8'h5A);
        bus(32'h0001_FFFF, 1'b0, 8'h00);
        check("ram_1ffff", cpu_din, 8'h5A);
        bus(32'h0000_0000, 1'b1, 8'h11);

        // TX fill with the UART stalled: zero filter, high-water mark, overflow
        tx_ready = 1'b0;
        bus(32'h0003_0000, 1'b1, 8'h41);
        bus(32'h0003_0000, 1'b1, 8'h00);
        bus(32'h0003_0000, 1'b1, 8'h42);
        check("tx_head", tx_data, 8'h41);
        check("tx_occ2_notfull", io_buffer_full, 1'b0);
        for (int i = 0; i < 4; i++) bus(32'h0003_0000, 1'b1, 8'h50 + 8'(i));
        check("tx_full_at_6", io_buffer_full, 1'b1);
        for (int i = 0; i < 3; i++) bus(32'h0003_0000, 1'b1, 8'h60 + 8'(i));
        check("tx_overflow_set", tx_overflow, 1'b1);
        // Push and pop together on a full FIFO: accepted, model tracks it
        tx_ready = 1'b1;
        bus(32'h0003_0000, 1'b1, 8'h77);
        for (int i = 0; i < 10; i++) bus(32'h0000_0000, 1'b0, 8'h00);
        check("tx_drained", tx_valid, 1'b0);

        // RX holding byte
        tx_ready = 1'b0;
        rx_data = 8'h37; rx_valid = 1'b1;
        bus(32'h0000_0000, 1'b0, 8'h00);
        rx_valid = 1'b0;
        check("rx_held", rx_ready, 1'b0);
        bus(32'h0003_0000, 1'b0, 8'h00);
        check("rx_read", cpu_din, 8'h37);
        bus(32'h0000_0000, 1'b0, 8'h00);
        check("rx_ready_after", rx_ready, 1'b1);
        bus(32'h0003_0000, 1'b0, 8'h00);
        check("rx_second_read", cpu_din, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            pool[i] = $urandom_range(0, 32'h1FFFF);
            bus(pool[i], 1'b1, 8'($urandom));
        end
        for (int i = 0; i < 500; i++) begin
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: bus(pool[$urandom_range(0, 15)], 1'b1, d);
                3, 4:    bus(pool[$urandom_range(0, 15)], 1'b0, 8'h00);
                5:       bus(32'h0003_0000, 1'b1, d);
                6:       bus(32'h0003_0000, 1'b0, 8'h00);
                7:       bus(32'h0003_0004 + $urandom_range(0, 3), 1'b0, 8'h00);
                8:       bus(32'h0003_0008 + $urandom_range(0, 7), 1'($urandom), d);
                default: bus(32'h0003_0001 + $urandom_range(0, 2), 1'b0, 8'h00);
            endcase
        end
        rx_valid = 1'b0;

        // Counter after a fresh reset and 300 idle cycles
        async_reset("rst_cnt");
        tx_ready = 1'b0;
        for (int i = 0; i < 300; i++) bus(32'h0000_0000, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) bus(32'h0003_0004 + i, 1'b0, 8'h00);

        // Program stop: pushes 0x00, sets the latch, freezes the counter
        bus(32'h0003_0000, 1'b1, 8'h21);
        bus(32'h0003_0004, 1'b1, 8'hFF);
        check("stop_set", program_stop, 1'b1);
        check("stop_push_zero", 32'(txq.size()), 32'd2);
        for (int i = 0; i < 5; i++) bus(32'h0000_0000, 1'b0, 8'h00);
        bus(32'h0003_0004, 1'b0, 8'h00);
        bus(32'h0003_0005, 1'b0, 8'h00);

        // Async reset while the FIFO is draining
        for (int i = 0; i < 5; i++) bus(32'h0003_0000, 1'b1, 8'h80 + 8'(i));
        tx_ready = 1'b1;
        bus(32'h0003_0004, 1'b0, 8'h00);
        bus(32'h0000_0000, 1'b0, 8'h00);
        async_reset("rst_drain");
        tx_ready = 1'b0;
        bus(32'h0003_0004, 1'b0, 8'h00);
        check("cnt_after_reset", cpu_din, 8'h00);
        bus(32'h0003_0004, 1'b0, 8'h00);
        check("cnt_counting", cpu_din, 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
